// File: rtl/game_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// game_sequencer
//
// Top-level play controller for the snake game datapath.
//   * Steps the game through IDLE -> RUN <-> PAUSE, and RUN -> OVER.
//   * Generates the snake move tick. The move period shrinks as the score
//     grows and never drops below TICK_MIN.
//   * Issues a one-cycle synchronous game reset (sync) to the body
//     controller, the apple/obstacle generators and the score tracker
//     whenever a game is started or restarted.
//   * Holds a move tick back until the display has finished drawing the
//     previous frame (frame_req / frame_done handshake).
//
// Ports
//   clk         in   1      system clock
//   rst         in   1      asynchronous reset, active-high
//   start_pb    in   1      start/restart pulse (already synchronised, edge-detected)
//   pause_pb    in   1      pause toggle pulse (already synchronised, edge-detected)
//   bad_coll    in   1      head hit border, obstacle or body
//   score       in   8      current score, unsigned
//   frame_done  in   1      one-cycle pulse: image generator finished a frame
//   sync        out  1      one-cycle synchronous game reset (Mealy)
//   move_tick   out  1      one-cycle pulse: advance snake one cell (Mealy)
//   frame_req   out  1      redraw requested, held until frame_done
//   game_over   out  1      high while in OVER
//   state       out  2      0=IDLE 1=RUN 2=PAUSE 3=OVER
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int TICK_BASE  = 1_500_000,
    parameter int TICK_MIN   = 300_000,
    parameter int SPEED_STEP = 20_000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pb,
    input  logic       pause_pb,
    input  logic       bad_coll,
    input  logic [7:0] score,
    input  logic       frame_done,
    output logic       sync,
    output logic       move_tick,
    output logic       frame_req,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    // The score product is formed 8 bits wider than the counter so that no
    // parameter combination can wrap it and produce a bogus long period.
    localparam int RW = CNT_W + 8;

    // Move period for a given score, clamped at TICK_MIN. The comparison is
    // done before the subtraction so TICK_BASE - red can never underflow.
    function automatic logic [CNT_W-1:0] calc_period(input logic [7:0] sc);
        logic [RW-1:0] red;
        logic [RW-1:0] base_w;
        logic [RW-1:0] span_w;
        red    = RW'(sc) * RW'(SPEED_STEP);
        base_w = RW'(TICK_BASE);
        span_w = RW'(TICK_BASE - TICK_MIN);
        if (red >= span_w) begin
            return CNT_W'(TICK_MIN);
        end
        return CNT_W'(base_w - red);
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             frame_req_q, frame_req_d;
    logic             game_over_q, game_over_d;
    logic             sync_c;
    logic             tick_c;
    logic [CNT_W-1:0] period_c;
    logic [CNT_W-1:0] reload_c;

    // Counter reload value; score is sampled in the cycle the load happens.
    assign period_c = calc_period(score);
    assign reload_c = period_c - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_req_d = frame_req_q;
        game_over_d = game_over_q;
        sync_c      = 1'b0;
        tick_c      = 1'b0;

        // The redraw handshake completes in every state, including PAUSE.
        if (frame_req_q && frame_done) begin
            frame_req_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_pb) begin
                    sync_c      = 1'b1;
                    cnt_d       = reload_c;
                    frame_req_d = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = S_RUN;
                end
            end

            S_RUN: begin
                if (start_pb) begin
                    sync_c      = 1'b1;
                    cnt_d       = reload_c;
                    frame_req_d = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = S_RUN;
                end else if (bad_coll) begin
                    // Collision wins over a tick due in the same cycle.
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else if (pause_pb) begin
                    // The counter is not decremented in the cycle the pause
                    // is taken, so it resumes from exactly this value.
                    state_d = S_PAUSE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!frame_req_q) begin
                    tick_c      = 1'b1;
                    frame_req_d = 1'b1;
                    cnt_d       = reload_c;
                end
                // cnt_q == 0 with a frame still pending: stall at zero.
            end

            S_PAUSE: begin
                if (start_pb) begin
                    sync_c      = 1'b1;
                    cnt_d       = reload_c;
                    frame_req_d = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = S_RUN;
                end else if (pause_pb) begin
                    state_d = S_RUN;
                end
            end

            S_OVER: begin
                if (start_pb) begin
                    sync_c      = 1'b1;
                    cnt_d       = reload_c;
                    frame_req_d = 1'b0;
                    game_over_d = 1'b0;
                    state_d     = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_req_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_req_q <= frame_req_d;
            game_over_q <= game_over_d;
        end
    end

    // sync is gated with rst so a start press during reset cannot leak a
    // datapath reset; move_tick is already zero because state_q is IDLE.
    assign sync      = sync_c & ~rst;
    assign move_tick = tick_c;
    assign frame_req = frame_req_q;
    assign game_over = game_over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_pb;
    logic       pause_pb;
    logic       bad_coll;
    logic [7:0] score;
    logic       frame_done;
    logic       sync;
    logic       move_tick;
    logic       frame_req;
    logic       game_over;
    logic [1:0] state;

    logic       fd_auto = 1'b0;
    logic       fd_man  = 1'b0;
    logic       auto_en = 1'b1;
    int         fd_cnt  = 0;
    int         cyc     = 0;
    int         checks  = 0;
    int         errors  = 0;

    typedef struct {
        int kind;   // 0 = sync, 1 = move_tick
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    assign frame_done = fd_auto | fd_man;

    game_sequencer #(
        .TICK_BASE (20),
        .TICK_MIN  (8),
        .SPEED_STEP(2),
        .CNT_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_pb  (start_pb),
        .pause_pb  (pause_pb),
        .bad_coll  (bad_coll),
        .score     (score),
        .frame_done(frame_done),
        .sync      (sync),
        .move_tick (move_tick),
        .frame_req (frame_req),
        .game_over (game_over),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Display model: answers each frame_req with frame_done two cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_en && frame_req === 1'b1) fd_cnt = fd_cnt + 1;
            else fd_cnt = 0;
            fd_auto = (fd_cnt == 2);
        end
    end

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_%s: pulse at cycle %0d, required none",
                     (kind == 0) ? "sync" : "tick", cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors = errors + 1;
                $display("FAIL pulse_order: got %s at cycle %0d, required %s at cycle %0d",
                         (kind == 0) ? "sync" : "tick", cyc,
                         (e.kind == 0) ? "sync" : "tick", e.cyc);
            end
        end
    endtask

    // Monitor: every sync/move_tick pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (sync === 1'b1)      check_ev(0);
        if (move_tick === 1'b1) check_ev(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int u;
        rst      = 1'b1;
        start_pb = 1'b0;
        pause_pb = 1'b0;
        bad_coll = 1'b0;
        score    = 8'd0;
        step();
        chk("reset_state", {6'd0, state}, 8'd0);
        chk("reset_outputs", {3'd0, sync, move_tick, frame_req, game_over, 1'b0}, 8'd0);
        step();
        rst = 1'b0;
        step();
        chk("idle_state", {6'd0, state}, 8'd0);

        // 1: start, steady period 20 at score 0
        wait_until(5);
        s = cyc;
        push_ev(0, s);
        push_ev(1, s + 20);
        push_ev(1, s + 40);
        push_ev(1, s + 60);
        push_ev(1, s + 80);
        start_pb = 1'b1;
        step();
        start_pb = 1'b0;
        chk("run_after_start", {6'd0, state}, 8'd1);
        chk("no_game_over", {7'd0, game_over}, 8'd0);

        // 2: score-dependent period: 4 -> 12, 7 -> clamp 8, 255 -> 8
        wait_until(s + 61);
        score = 8'd4;
        push_ev(1, s + 92);
        wait_until(s + 93);
        score = 8'd7;
        push_ev(1, s + 104);
        push_ev(1, s + 112);
        wait_until(s + 113);
        score = 8'd255;
        push_ev(1, s + 120);
        push_ev(1, s + 128);
        wait_until(s + 129);
        score = 8'd0;
        push_ev(1, s + 136);

        // 3: display stall; tick deferred until frame_done
        wait_until(s + 132);
        auto_en = 1'b0;
        wait_until(s + 160);
        chk("frame_req_held", {7'd0, frame_req}, 8'd1);
        wait_until(s + 166);
        push_ev(1, s + 167);
        push_ev(1, s + 187);
        fd_man = 1'b1;
        step();
        fd_man = 1'b0;
        chk("frame_req_after_tick", {7'd0, frame_req}, 8'd0);
        wait_until(s + 170);
        auto_en = 1'b1;

        // 4: pause 7 cycles after a tick, resume 100 cycles later
        wait_until(s + 194);
        pause_pb = 1'b1;
        step();
        pause_pb = 1'b0;
        chk("paused_state", {6'd0, state}, 8'd2);
        wait_until(s + 295);
        push_ev(1, s + 309);
        push_ev(1, s + 329);
        pause_pb = 1'b1;
        step();
        pause_pb = 1'b0;
        chk("resumed_state", {6'd0, state}, 8'd1);

        // 5: collision and pause coincide on a due tick
        wait_until(s + 349);
        bad_coll = 1'b1;
        pause_pb = 1'b1;
        step();
        bad_coll = 1'b0;
        pause_pb = 1'b0;
        chk("over_state", {6'd0, state}, 8'd3);
        chk("over_flag", {7'd0, game_over}, 8'd1);
        wait_until(s + 360);
        chk("over_hold", {6'd0, state}, 8'd3);
        push_ev(0, s + 360);
        push_ev(1, s + 380);
        start_pb = 1'b1;
        step();
        start_pb = 1'b0;
        chk("restart_state", {6'd0, state}, 8'd1);
        chk("restart_game_over", {7'd0, game_over}, 8'd0);

        // 6: async reset while a frame is pending, then start+pause in IDLE
        wait_until(s + 381);
        chk("pending_frame", {7'd0, frame_req}, 8'd1);
        #2;
        rst      = 1'b1;
        start_pb = 1'b1;
        #1;
        chk("abort_state", {6'd0, state}, 8'd0);
        chk("abort_outputs", {3'd0, sync, move_tick, frame_req, game_over, 1'b0}, 8'd0);
        wait_until(s + 384);
        start_pb = 1'b0;
        rst      = 1'b0;
        wait_until(s + 390);
        u = cyc;
        push_ev(0, u);
        push_ev(1, u + 20);
        start_pb = 1'b1;
        pause_pb = 1'b1;
        step();
        start_pb = 1'b0;
        pause_pb = 1'b0;
        chk("start_beats_pause", {6'd0, state}, 8'd1);
        wait_until(u + 22);

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
